// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg                                                                    |
// | Shared mode codes, FSM encoding and resolution helpers for the VGA engine. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;
    localparam logic [1:0] MODE_NOP     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unrecognised resolution strings fall back to 640x480.
    function automatic int res_x(input logic [55:0] res);
        if (res == "320x240")      return 320;
        else if (res == "160x120") return 160;
        else                       return 640;
    endfunction

    function automatic int res_y(input logic [55:0] res);
        if (res == "320x240")      return 240;
        else if (res == "160x120") return 120;
        else                       return 480;
    endfunction

    function automatic int nx_of(input logic [55:0] res);
        if (res == "320x240")      return 9;
        else if (res == "160x120") return 8;
        else                       return 10;
    endfunction

    function automatic int ny_of(input logic [55:0] res);
        if (res == "320x240")      return 8;
        else if (res == "160x120") return 7;
        else                       return 9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_xy_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_xy_scan                                                                |
// | Row-major 2-D position counter over a loaded rectangle with a last flag.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_xy_scan #(
    parameter int NX = 10,
    parameter int NY = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [NX-1:0] i_x0,
    input  logic [NY-1:0] i_y0,
    input  logic [NX-1:0] i_xe,
    input  logic [NY-1:0] i_ye,
    output logic [NX-1:0] o_x,
    output logic [NY-1:0] o_y,
    output logic [NX-1:0] o_x_nxt,
    output logic [NY-1:0] o_y_nxt,
    output logic          o_last
);

    logic [NX-1:0] x_q, x_d, x0_q, x0_d, xe_q, xe_d;
    logic [NY-1:0] y_q, y_d, ye_q, ye_d;

    always_comb begin
        o_x_nxt = x_q + NX'(1);
        o_y_nxt = y_q;
        if (x_q == xe_q) begin
            o_x_nxt = x0_q;
            o_y_nxt = y_q + NY'(1);
        end

        x_d  = x_q;
        y_d  = y_q;
        x0_d = x0_q;
        xe_d = xe_q;
        ye_d = ye_q;
        if (i_load) begin
            x_d  = i_x0;
            y_d  = i_y0;
            x0_d = i_x0;
            xe_d = i_xe;
            ye_d = i_ye;
        end else if (i_step) begin
            x_d = o_x_nxt;
            y_d = o_y_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            xe_q <= xe_d;
            ye_q <= ye_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = (x_q == xe_q) && (y_q == ye_q);

endmodule
`default_nettype wire

// File: rtl/vga_rect_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_rect_engine                                                            |
// | Fill/outline/clear rectangle drawer emitting one clipped pixel per cycle.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_rect_engine
    import vga_pkg::*;
#(
    parameter logic [55:0] RESOLUTION  = "640x480",
    parameter int          COLOR_DEPTH = 9,
    localparam int         NX          = nx_of(RESOLUTION),
    localparam int         NY          = ny_of(RESOLUTION)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_mode,
    input  logic [NX-1:0]          cmd_x0,
    input  logic [NY-1:0]          cmd_y0,
    input  logic [NX:0]            cmd_w,
    input  logic [NY:0]            cmd_h,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    output logic [NX-1:0]          x,
    output logic [NY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam int            XMAX  = res_x(RESOLUTION);
    localparam int            YMAX  = res_y(RESOLUTION);
    localparam logic [NX+1:0] XLAST = (NX+2)'(XMAX - 1);
    localparam logic [NY+1:0] YLAST = (NY+2)'(YMAX - 1);

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   write_q, write_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   outline_q, outline_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic [NX-1:0]          x0_q, x0_d;
    logic [NY-1:0]          y0_q, y0_d;
    logic [NX+1:0]          xr_q, xr_d;
    logic [NY+1:0]          yr_q, yr_d;

    logic [NX-1:0] w_eff_x0, w_clip_xe, w_scan_x, w_scan_x_nxt;
    logic [NY-1:0] w_eff_y0, w_clip_ye, w_scan_y, w_scan_y_nxt;
    logic [NX:0]   w_eff_w;
    logic [NY:0]   w_eff_h;
    logic [NX+1:0] w_right;
    logic [NY+1:0] w_bottom;
    logic          w_empty, w_accept, w_on_edge;
    logic          w_scan_load, w_scan_step, w_scan_last;

    // Edge sums carry two extra bits so an oversized rectangle clips instead of wrapping.
    always_comb begin
        w_eff_x0 = cmd_x0;
        w_eff_y0 = cmd_y0;
        w_eff_w  = cmd_w;
        w_eff_h  = cmd_h;
        if (cmd_mode == MODE_CLEAR) begin
            w_eff_x0 = '0;
            w_eff_y0 = '0;
            w_eff_w  = (NX+1)'(XMAX);
            w_eff_h  = (NY+1)'(YMAX);
        end
        w_right   = {2'b00, w_eff_x0} + {1'b0, w_eff_w} - (NX+2)'(1);
        w_bottom  = {2'b00, w_eff_y0} + {1'b0, w_eff_h} - (NY+2)'(1);
        w_clip_xe = (w_right  > XLAST) ? XLAST[NX-1:0] : w_right[NX-1:0];
        w_clip_ye = (w_bottom > YLAST) ? YLAST[NY-1:0] : w_bottom[NY-1:0];
        w_empty   = (cmd_mode == MODE_NOP) || (w_eff_w == '0) || (w_eff_h == '0)
                    || (w_eff_x0 >= NX'(XMAX)) || (w_eff_y0 >= NY'(YMAX));
    end

    assign w_accept  = cmd_valid && cmd_ready_q;
    assign w_on_edge = (w_scan_x_nxt == x0_q) || (w_scan_y_nxt == y0_q)
                       || ({2'b00, w_scan_x_nxt} == xr_q) || ({2'b00, w_scan_y_nxt} == yr_q);

    always_comb begin
        state_d     = state_q;
        write_d     = 1'b0;
        color_d     = color_q;
        outline_d   = outline_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        xr_d        = xr_q;
        yr_d        = yr_q;
        w_scan_load = 1'b0;
        w_scan_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    color_d   = cmd_color;
                    outline_d = (cmd_mode == MODE_OUTLINE);
                    x0_d      = w_eff_x0;
                    y0_d      = w_eff_y0;
                    xr_d      = w_right;
                    yr_d      = w_bottom;
                    if (w_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_DRAW;
                        w_scan_load = 1'b1;
                        write_d     = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (w_scan_last) begin
                    state_d = ST_DONE;
                end else begin
                    w_scan_step = 1'b1;
                    write_d     = !outline_q || w_on_edge;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_DRAW);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            outline_q   <= 1'b0;
            color_q     <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            xr_q        <= '0;
            yr_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            outline_q   <= outline_d;
            color_q     <= color_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
        end
    end

    vga_xy_scan #(
        .NX (NX),
        .NY (NY)
    ) u_scan (
        .clk     (clock),
        .rst     (reset),
        .i_load  (w_scan_load),
        .i_step  (w_scan_step),
        .i_x0    (w_eff_x0),
        .i_y0    (w_eff_y0),
        .i_xe    (w_clip_xe),
        .i_ye    (w_clip_ye),
        .o_x     (w_scan_x),
        .o_y     (w_scan_y),
        .o_x_nxt (w_scan_x_nxt),
        .o_y_nxt (w_scan_y_nxt),
        .o_last  (w_scan_last)
    );

    assign cmd_ready = cmd_ready_q;
    assign x         = w_scan_x;
    assign y         = w_scan_y;
    assign color     = color_q;
    assign write     = write_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_rect_engine                                                         |
// | Directed bench over 160x120, 320x240 and 640x480 instances of the engine.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vga_rect_engine;
    import vga_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]  vld       = '0;
    logic [1:0]  cmd_mode  = '0;
    logic [9:0]  cmd_x0    = '0;
    logic [8:0]  cmd_y0    = '0;
    logic [10:0] cmd_w     = '0;
    logic [9:0]  cmd_h     = '0;
    logic [8:0]  cmd_color = '0;

    wire [2:0] rdy, wr, bsy, dn;
    wire [7:0] x_a;
    wire [6:0] y_a;
    wire [8:0] c_a, x_b, c_b, y_c, c_c;
    wire [7:0] y_b;
    wire [9:0] x_c;

    vga_rect_engine #(.RESOLUTION("160x120"), .COLOR_DEPTH(9)) u_160 (
        .clock(clock), .reset(reset), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
        .cmd_mode(cmd_mode), .cmd_x0(cmd_x0[7:0]), .cmd_y0(cmd_y0[6:0]),
        .cmd_w(cmd_w[8:0]), .cmd_h(cmd_h[7:0]), .cmd_color(cmd_color),
        .x(x_a), .y(y_a), .color(c_a), .write(wr[0]), .busy(bsy[0]), .done(dn[0]));

    vga_rect_engine #(.RESOLUTION("320x240"), .COLOR_DEPTH(9)) u_320 (
        .clock(clock), .reset(reset), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
        .cmd_mode(cmd_mode), .cmd_x0(cmd_x0[8:0]), .cmd_y0(cmd_y0[7:0]),
        .cmd_w(cmd_w[9:0]), .cmd_h(cmd_h[8:0]), .cmd_color(cmd_color),
        .x(x_b), .y(y_b), .color(c_b), .write(wr[1]), .busy(bsy[1]), .done(dn[1]));

    vga_rect_engine #(.RESOLUTION("640x480"), .COLOR_DEPTH(9)) u_640 (
        .clock(clock), .reset(reset), .cmd_valid(vld[2]), .cmd_ready(rdy[2]),
        .cmd_mode(cmd_mode), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
        .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .x(x_c), .y(y_c), .color(c_c), .write(wr[2]), .busy(bsy[2]), .done(dn[2]));

    int         sel = 0;
    logic [9:0] ox;
    logic [8:0] oy, ocol;
    logic       ordy, ow, ob, od;

    always_comb begin
        ordy = rdy[sel];
        ow   = wr[sel];
        ob   = bsy[sel];
        od   = dn[sel];
        ox   = {2'b00, x_a};
        oy   = {2'b00, y_a};
        ocol = c_a;
        if (sel == 1) begin
            ox = {1'b0, x_b}; oy = {1'b0, y_b}; ocol = c_b;
        end else if (sel == 2) begin
            ox = x_c; oy = y_c; ocol = c_c;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int wq[$];
    int done_cyc, col_bad, busy_bad;

    int t2e[6] = '{10*1024+5, 11*1024+5, 12*1024+5, 10*1024+6, 11*1024+6, 12*1024+6};
    int t3e[2] = '{158*1024+119, 159*1024+119};
    int t4e[10] = '{0, 1024, 2048, 3072, 1, 3*1024+1, 2, 1024+2, 2048+2, 3*1024+2};
    int t6e[8] = '{636*1024+478, 637*1024+478, 638*1024+478, 639*1024+478,
                   636*1024+479, 637*1024+479, 638*1024+479, 639*1024+479};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wr_at(input int i);
        return (i < wq.size()) ? wq[i] : -1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " x"}, ox, 0);
        chk({tag, " y"}, oy, 0);
        chk({tag, " color"}, ocol, 0);
        chk({tag, " write"}, ow, 0);
        chk({tag, " busy"}, ob, 0);
        chk({tag, " done"}, od, 0);
        chk({tag, " cmd_ready"}, ordy, 0);
    endtask

    task automatic issue(input int s, input logic [1:0] m, input int x0, input int y0,
                         input int w, input int h, input int c);
        int k = 0;
        sel       = s;
        cmd_mode  = m;
        cmd_x0    = 10'(x0);
        cmd_y0    = 9'(y0);
        cmd_w     = 11'(w);
        cmd_h     = 10'(h);
        cmd_color = 9'(c);
        vld[s]    = 1'b1;
        #1;
        while (!ordy && k < 20) begin
            tick();
            k++;
        end
        chk("cmd_ready before accept", ordy, 1);
        tick();
        vld[s] = 1'b0;
    endtask

    // Called on the first cycle after accept; leaves the bench on the done cycle.
    task automatic collect(input int limit, input int exp_col, input int pulse_at);
        int cyc = 1;
        wq.delete();
        col_bad  = 0;
        busy_bad = 0;
        while (!od && cyc <= limit) begin
            if (ow) wq.push_back(int'(ox) * 1024 + int'(oy));
            if (ob !== 1'b1) busy_bad++;
            if (int'(ocol) != exp_col) col_bad++;
            if (cyc == pulse_at) begin
                cmd_mode = MODE_FILL; cmd_x0 = 10'd1; cmd_y0 = 9'd1; cmd_w = 11'd1; cmd_h = 10'd1;
                vld[sel] = 1'b1;
            end
            if (cyc == pulse_at + 3) vld[sel] = 1'b0;
            tick();
            cyc++;
        end
        done_cyc = cyc;
        chk("done reached", od, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // T1a: reset state and release
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        chk("ready at release", ordy, 0);
        tick();
        chk("ready after release", ordy, 1);

        // T2: small fill
        issue(0, MODE_FILL, 10, 5, 3, 2, 'h1FF);
        chk("t2 first write", ow, 1);
        collect(50, 'h1FF, 0);
        chk("t2 count", wq.size(), 6);
        for (int i = 0; i < 6; i++) chk("t2 pixel", wr_at(i), t2e[i]);
        chk("t2 done cycle", done_cyc, 7);
        chk("t2 busy at done", ob, 0);
        chk("t2 write at done", ow, 0);
        chk("t2 x hold", ox, 12);
        chk("t2 y hold", oy, 6);
        chk("t2 busy during draw", busy_bad, 0);
        chk("t2 color during draw", col_bad, 0);
        tick();
        chk("t2 ready after done", ordy, 1);
        chk("t2 done single pulse", od, 0);

        // T3: corner clip, no wrap
        issue(0, MODE_FILL, 158, 119, 5, 4, 'h0AA);
        collect(50, 'h0AA, 0);
        chk("t3 count", wq.size(), 2);
        for (int i = 0; i < 2; i++) chk("t3 pixel", wr_at(i), t3e[i]);
        chk("t3 done cycle", done_cyc, 3);

        // T4: outline 4x3
        issue(1, MODE_OUTLINE, 0, 0, 4, 3, 'h055);
        collect(50, 'h055, 0);
        chk("t4 count", wq.size(), 10);
        for (int i = 0; i < 10; i++) chk("t4 pixel", wr_at(i), t4e[i]);
        chk("t4 done cycle", done_cyc, 13);

        // 640x480 bottom-right clip
        issue(2, MODE_FILL, 636, 478, 10, 5, 'h123);
        collect(50, 'h123, 0);
        chk("t640 count", wq.size(), 8);
        for (int i = 0; i < 8; i++) chk("t640 pixel", wr_at(i), t6e[i]);
        chk("t640 done cycle", done_cyc, 9);

        // T5: clear screen at 160x120 with a stray valid mid-draw
        tick();
        issue(0, MODE_CLEAR, 7, 7, 3, 3, 0);
        collect(20000, 0, 100);
        chk("t5 count", wq.size(), 19200);
        chk("t5 first", wr_at(0), 0);
        chk("t5 last", wr_at(19199), 159*1024+119);
        chk("t5 done cycle", done_cyc, 19201);
        chk("t5 color", col_bad, 0);
        tick();
        tick();
        chk("t5 stray ignored busy", ob, 0);
        chk("t5 stray ignored ready", ordy, 1);

        // T6: zero-write commands, accepts two cycles apart
        issue(0, MODE_NOP, 10, 10, 5, 5, 1);
        chk("t6 nop done", od, 1);
        chk("t6 nop write", ow, 0);
        chk("t6 nop busy", ob, 0);
        chk("t6 nop ready low", ordy, 0);
        tick();
        chk("t6 nop ready", ordy, 1);
        issue(0, MODE_FILL, 10, 10, 0, 5, 2);
        chk("t6 w0 done", od, 1);
        chk("t6 w0 write", ow, 0);
        tick();
        chk("t6 w0 ready", ordy, 1);
        issue(0, MODE_FILL, 200, 10, 5, 5, 3);
        chk("t6 x0 done", od, 1);
        chk("t6 x0 write", ow, 0);
        tick();
        chk("t6 x0 ready", ordy, 1);

        // T1b: reset mid-draw aborts
        issue(0, MODE_FILL, 0, 0, 20, 20, 'h1FF);
        repeat (5) tick();
        chk("t1 mid-draw write", ow, 1);
        reset = 1'b1;
        repeat (3) tick();
        chk_zero("mid reset");
        reset = 1'b0;
        tick();
        chk("t1 ready after abort", ordy, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (od || ow) seen++;
            tick();
        end
        chk("t1 no done or write after abort", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
